// File: rtl/gen_al_n2w_top.sv
`default_nettype none
// ============================================================================
// Module   : gen_al_n2w_top
// Brief    : Narrow-to-wide aligner. Packs DAT_IN_W-bit beats into one
//            DAT_OUT_W-bit word, lane 0 first, and reports the index of the
//            last valid lane. us_last closes a word early.
// Option   : GEN_AL_N2W_ZERO_PAD_EN - lanes above ds_last_vld_sel are zero.
//            When undefined, those lanes carry stale data (don't-care).
// Revision : 1.0 - initial release
// ============================================================================
module gen_al_n2w_top #(
    parameter int DAT_IN_W  = 8,
    parameter int DAT_OUT_W = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    us_vld,
    input  logic                                    us_last,
    input  logic [DAT_IN_W-1:0]                     us_dat,
    output logic                                    us_rdy,
    output logic                                    ds_vld,
    input  logic                                    ds_rdy,
    output logic [DAT_OUT_W-1:0]                    ds_dat,
    output logic [$clog2(DAT_OUT_W/DAT_IN_W)-1:0]   ds_last_vld_sel
);

    localparam int c_N      = DAT_OUT_W / DAT_IN_W;
    localparam int AL_SEL_W = $clog2(c_N);
    localparam logic [AL_SEL_W-1:0] c_LAST_LANE = AL_SEL_W'(c_N - 1);

    logic [AL_SEL_W-1:0]  r_cnt_q,     w_cnt_d;
    logic [DAT_OUT_W-1:0] r_asm_q,     w_asm_d;
    logic                 r_ds_vld_q,  w_ds_vld_d;
    logic [DAT_OUT_W-1:0] r_ds_dat_q,  w_ds_dat_d;
    logic [AL_SEL_W-1:0]  r_ds_sel_q,  w_ds_sel_d;

    logic                 w_accept;
    logic                 w_complete;
    logic [DAT_OUT_W-1:0] w_merged;

    // Upstream ready depends only on the output register state and ds_rdy.
    assign us_rdy     = ~r_ds_vld_q | ds_rdy;
    assign w_accept   = us_vld & us_rdy;
    assign w_complete = w_accept & (us_last | (r_cnt_q == c_LAST_LANE));

    // Assembly word with the incoming beat written into lane cnt.
    always_comb begin
        w_merged = r_asm_q;
        for (int k = 0; k < c_N; k++) begin
            if (r_cnt_q == AL_SEL_W'(k)) begin
                w_merged[k*DAT_IN_W +: DAT_IN_W] = us_dat;
            end
        end
    end

    // Next-state for lane counter, assembly and output registers.
    always_comb begin
        w_cnt_d    = r_cnt_q;
        w_asm_d    = r_asm_q;
        w_ds_vld_d = w_complete | (r_ds_vld_q & ~ds_rdy);
        w_ds_dat_d = r_ds_dat_q;
        w_ds_sel_d = r_ds_sel_q;
        if (w_accept) begin
            w_asm_d = w_merged;
            w_cnt_d = r_cnt_q + AL_SEL_W'(1);
        end
        if (w_complete) begin
            w_cnt_d    = '0;
            w_ds_dat_d = w_merged;
            w_ds_sel_d = r_cnt_q;
`ifdef GEN_AL_N2W_ZERO_PAD_EN
            // Clearing here keeps every lane above the next word's last lane zero.
            w_asm_d    = '0;
`endif
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q    <= '0;
            r_asm_q    <= '0;
            r_ds_vld_q <= 1'b0;
            r_ds_dat_q <= '0;
            r_ds_sel_q <= '0;
        end else begin
            r_cnt_q    <= w_cnt_d;
            r_asm_q    <= w_asm_d;
            r_ds_vld_q <= w_ds_vld_d;
            r_ds_dat_q <= w_ds_dat_d;
            r_ds_sel_q <= w_ds_sel_d;
        end
    end

    assign ds_vld          = r_ds_vld_q;
    assign ds_dat          = r_ds_dat_q;
    assign ds_last_vld_sel = r_ds_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_gen_al_n2w_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_al_n2w_top
// Brief    : Self-checking bench for gen_al_n2w_top (8 -> 32 bits).
//            Expected words are built from accepted beats and queued; a
//            monitor pops and compares them at each output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen_al_n2w_top;

    localparam int c_IN  = 8;
    localparam int c_OUT = 32;
    localparam int c_N   = c_OUT / c_IN;

    typedef struct packed {
        logic [c_OUT-1:0] dat;
        logic [1:0]       sel;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             us_vld;
    logic             us_last;
    logic [c_IN-1:0]  us_dat;
    logic             us_rdy;
    logic             ds_vld;
    logic             ds_rdy;
    logic [c_OUT-1:0] ds_dat;
    logic [1:0]       ds_last_vld_sel;

    exp_t            exp_q[$];
    logic [c_IN-1:0] pkt[$];
    int              n_vec = 0;
    int              n_err = 0;

    gen_al_n2w_top #(.DAT_IN_W(c_IN), .DAT_OUT_W(c_OUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .us_vld          (us_vld),
        .us_last         (us_last),
        .us_dat          (us_dat),
        .us_rdy          (us_rdy),
        .ds_vld          (ds_vld),
        .ds_rdy          (ds_rdy),
        .ds_dat          (ds_dat),
        .ds_last_vld_sel (ds_last_vld_sel)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: a word is consumed at the next posedge when vld & rdy.
    always @(negedge clk) begin
        if (!rst && ds_vld && ds_rdy) begin
            exp_t             e;
            logic [c_OUT-1:0] mask;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_word: got dat=%08h sel=%0d, required no word", ds_dat, ds_last_vld_sel);
            end else begin
                e = exp_q.pop_front();
`ifdef GEN_AL_N2W_ZERO_PAD_EN
                mask = '1;
`else
                mask = '0;
                for (int k = 0; k <= int'(e.sel); k++) mask[k*c_IN +: c_IN] = '1;
`endif
                if (((ds_dat & mask) !== (e.dat & mask)) || (ds_last_vld_sel !== e.sel)) begin
                    n_err++;
                    $display("FAIL word: got dat=%08h sel=%0d, required dat=%08h sel=%0d (mask %08h)",
                             ds_dat, ds_last_vld_sel, e.dat, e.sel, mask);
                end
            end
        end
    end

    // Present one beat and hold it until accepted; records it in the model.
    task automatic send(input logic [c_IN-1:0] d, input logic l);
        bit done = 0;
        us_vld  = 1'b1;
        us_dat  = d;
        us_last = l;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (us_rdy) begin
                done = 1;
                pkt.push_back(d);
                if (l || pkt.size() == c_N) begin
                    exp_t e;
                    e.dat = '0;
                    for (int k = 0; k < pkt.size(); k++) e.dat[k*c_IN +: c_IN] = pkt[k];
                    e.sel = 2'(pkt.size() - 1);
                    exp_q.push_back(e);
                    pkt.delete();
                end
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: beat %02h not accepted, required acceptance within 50 cycles", d);
        end
    endtask

    task automatic idle();
        us_vld  = 1'b0;
        us_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; us_vld = 0; us_last = 0; us_dat = '0; ds_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ds_vld !== 1'b0 || ds_dat !== '0 || ds_last_vld_sel !== 2'd0 || us_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: got vld=%b dat=%08h sel=%0d rdy=%b, required 0 00000000 0 1",
                     ds_vld, ds_dat, ds_last_vld_sel, us_rdy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_words();
        logic [c_IN-1:0] b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            send(b[i], 1'b0);
            n_vec++;
            if (ds_vld !== (i == 3)) begin
                n_err++;
                $display("FAIL full_latency: beat %0d got ds_vld=%b, required %b", i, ds_vld, (i == 3));
            end
        end
        idle();
        n_vec++;
        if (ds_dat !== 32'h44332211 || ds_last_vld_sel !== 2'd3) begin
            n_err++;
            $display("FAIL full_word: got %08h sel=%0d, required 44332211 sel=3", ds_dat, ds_last_vld_sel);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_early_last();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        idle();
        n_vec++;
        if (ds_vld !== 1'b1 || ds_dat[15:0] !== 16'hBBAA || ds_last_vld_sel !== 2'd1) begin
            n_err++;
            $display("FAIL early_last: got vld=%b lanes=%04h sel=%0d, required 1 BBAA 1",
                     ds_vld, ds_dat[15:0], ds_last_vld_sel);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat();
        send(8'h5C, 1'b1);
        idle();
        n_vec++;
        if (ds_dat[7:0] !== 8'h5C || ds_last_vld_sel !== 2'd0) begin
            n_err++;
            $display("FAIL single_beat: got lane0=%02h sel=%0d, required 5C 0", ds_dat[7:0], ds_last_vld_sel);
        end
        send(8'h66, 1'b1);
        idle();
        n_vec++;
        if (ds_dat[7:0] !== 8'h66 || ds_last_vld_sel !== 2'd0) begin
            n_err++;
            $display("FAIL single_next_lane0: got lane0=%02h sel=%0d, required 66 0", ds_dat[7:0], ds_last_vld_sel);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        ds_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        us_vld = 1'b1; us_dat = 8'h55; us_last = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (us_rdy !== 1'b0 || ds_vld !== 1'b1 || ds_dat !== 32'h04030201 || ds_last_vld_sel !== 2'd3) begin
                n_err++;
                $display("FAIL backpressure_hold: cycle %0d got rdy=%b vld=%b dat=%08h sel=%0d, required 0 1 04030201 3",
                         c, us_rdy, ds_vld, ds_dat, ds_last_vld_sel);
            end
            @(posedge clk); #1;
        end
        ds_rdy = 1'b1;
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        idle();
        n_vec++;
        if (ds_dat !== 32'h88776655) begin
            n_err++;
            $display("FAIL backpressure_next: got %08h, required 88776655", ds_dat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            send(8'hC0 + 8'(i), 1'b0);
            n_vec++;
            if (ds_vld !== (i == 3 || i == 7)) begin
                n_err++;
                $display("FAIL b2b_vld: after beat %0d got ds_vld=%b, required %b", i, ds_vld, (i == 3 || i == 7));
            end
        end
        idle();
        n_vec++;
        if (ds_dat !== 32'hC7C6C5C4) begin
            n_err++;
            $display("FAIL b2b_second: got %08h, required C7C6C5C4", ds_dat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_packet();
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pkt.delete();
        n_vec++;
        if (ds_vld !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_vld: got ds_vld=%b, required 0", ds_vld);
        end
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        idle();
        n_vec++;
        if (ds_dat !== 32'h04030201 || ds_last_vld_sel !== 2'd3) begin
            n_err++;
            $display("FAIL reset_mid_word: got %08h sel=%0d, required 04030201 3", ds_dat, ds_last_vld_sel);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_drain();
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if (exp_q.size() != 0 || ds_vld !== 1'b0) begin
            n_err++;
            $display("FAIL drain: got %0d words outstanding, ds_vld=%b, required 0 and 0", exp_q.size(), ds_vld);
        end
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_early_last();
        test_single_beat();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_packet();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
